// File: rtl/ram_port_arbiter.sv
// Request/grant arbiter between NUM_CLIENTS engines and one read-first simple-dual-port RAM.
// Optional macro RAM_ARB_RAW_BYPASS_EN: forward same-cycle write data to a colliding read.
module ram_port_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 96,
  parameter int ADDR_W      = 8,
  parameter int RD_LAT      = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        wr_req,
  input  logic [NUM_CLIENTS-1:0]        wr_lock,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] wr_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wr_data,
  output logic [NUM_CLIENTS-1:0]        wr_gnt,
  input  logic [NUM_CLIENTS-1:0]        rd_req,
  input  logic [NUM_CLIENTS-1:0]        rd_lock,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_CLIENTS-1:0]        rd_gnt,
  output logic [NUM_CLIENTS-1:0]        rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          ram_wen,
  output logic [ADDR_W-1:0]             ram_waddr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic [ADDR_W-1:0]             ram_raddr,
  input  logic [DATA_W-1:0]             ram_rdata
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  typedef logic [IDX_W-1:0] idx_t;
  typedef struct packed {
    logic vld;
    idx_t idx;
  } pick_t;

  logic [ADDR_W-1:0] wr_addr_a [NUM_CLIENTS];
  logic [DATA_W-1:0] wr_data_a [NUM_CLIENTS];
  logic [ADDR_W-1:0] rd_addr_a [NUM_CLIENTS];

  pick_t wr_own, rd_own, wr_pick, rd_pick;
  idx_t  wr_ptr, rd_ptr;
  logic  wr_hold, rd_hold;
  pick_t tag_q [RD_LAT];
  logic [DATA_W-1:0] ret_data;

  // Fixed priority scans from 0; round robin scans from ptr and wraps.
  function automatic pick_t arbitrate(input logic [NUM_CLIENTS-1:0] req, input idx_t ptr);
    pick_t res;
    int    cand;
    res = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      cand = (ARB_MODE == 0) ? i : (int'(ptr) + i) % NUM_CLIENTS;
      if (req[idx_t'(cand)]) res = '{vld: 1'b1, idx: idx_t'(cand)};
    end
    return res;
  endfunction

  function automatic idx_t next_idx(input idx_t k);
    return (k == idx_t'(NUM_CLIENTS - 1)) ? '0 : k + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      wr_addr_a[i] = wr_addr[i*ADDR_W +: ADDR_W];
      wr_data_a[i] = wr_data[i*DATA_W +: DATA_W];
      rd_addr_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    wr_gnt  = '0;
    rd_gnt  = '0;
    wr_hold = wr_own.vld && wr_req[wr_own.idx] && wr_lock[wr_own.idx];
    rd_hold = rd_own.vld && rd_req[rd_own.idx] && rd_lock[rd_own.idx];
    wr_pick = wr_hold ? wr_own : arbitrate(wr_req, wr_ptr);
    rd_pick = rd_hold ? rd_own : arbitrate(rd_req, rd_ptr);
    if (rst && wr_pick.vld) wr_gnt[wr_pick.idx] = 1'b1;
    if (rst && rd_pick.vld) rd_gnt[rd_pick.idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_own <= '0;
      rd_own <= '0;
    end else begin
      wr_own <= wr_pick;
      rd_own <= rd_pick;
      if (wr_pick.vld && !wr_hold) wr_ptr <= next_idx(wr_pick.idx);
      if (rd_pick.vld && !rd_hold) rd_ptr <= next_idx(rd_pick.idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_raddr <= '0;
    end else begin
      ram_wen <= wr_pick.vld;
      if (wr_pick.vld) begin
        ram_waddr <= wr_addr_a[wr_pick.idx];
        ram_wdata <= wr_data_a[wr_pick.idx];
      end
      if (rd_pick.vld) ram_raddr <= rd_addr_a[rd_pick.idx];
    end
  end

  // Read tag travels alongside the RAM access; its last stage lines up with ram_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < RD_LAT; j++) tag_q[j] <= '0;
    end else begin
      tag_q[0] <= rd_pick;
      for (int j = 1; j < RD_LAT; j++) tag_q[j] <= tag_q[j-1];
    end
  end

`ifdef RAM_ARB_RAW_BYPASS_EN
  logic              byp_hit;
  logic              byp_vld  [RD_LAT];
  logic [DATA_W-1:0] byp_data [RD_LAT];

  assign byp_hit = wr_pick.vld && rd_pick.vld &&
                   (wr_addr_a[wr_pick.idx] == rd_addr_a[rd_pick.idx]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < RD_LAT; j++) byp_vld[j] <= 1'b0;
    end else begin
      byp_vld[0] <= byp_hit;
      for (int j = 1; j < RD_LAT; j++) byp_vld[j] <= byp_vld[j-1];
    end
  end

  // NOTE: the data stages carry no reset; byp_vld alone decides whether they are used.
  always_ff @(posedge clk) begin
    byp_data[0] <= wr_data_a[wr_pick.idx];
    for (int j = 1; j < RD_LAT; j++) byp_data[j] <= byp_data[j-1];
  end

  assign ret_data = byp_vld[RD_LAT-1] ? byp_data[RD_LAT-1] : ram_rdata;
`else
  assign ret_data = ram_rdata;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= '0;
      if (tag_q[RD_LAT-1].vld) begin
        rd_valid[tag_q[RD_LAT-1].idx] <= 1'b1;
        rd_data                       <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three configurations share one stimulus stream and are
// checked every cycle against a grant/latency model plus literal directed expectations.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int NI = 3;
  localparam int MODE [NI] = '{0, 1, 1};
  localparam int LAT  [NI] = '{1, 1, 3};
`ifdef RAM_ARB_RAW_BYPASS_EN
  localparam logic [DW-1:0] RAW_EXP = 96'hA5;
`else
  localparam logic [DW-1:0] RAW_EXP = 96'h3C;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    wr_req, wr_lock, rd_req, rd_lock;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*DW-1:0] wr_data;

  logic [N-1:0]  wr_gnt [NI];
  logic [N-1:0]  rd_gnt [NI];
  logic [N-1:0]  rd_valid [NI];
  logic [DW-1:0] rd_data [NI];
  logic          ram_wen [NI];
  logic [AW-1:0] ram_waddr [NI];
  logic [DW-1:0] ram_wdata [NI];
  logic [AW-1:0] ram_raddr [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DW-1:0] rdata;
    logic [DW-1:0] mem [256] = '{default: '0};
    logic [DW-1:0] pipe [2];

    ram_port_arbiter #(
      .NUM_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT[g]), .ARB_MODE(MODE[g])
    ) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_lock(wr_lock), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_gnt(wr_gnt[g]),
      .rd_req(rd_req), .rd_lock(rd_lock), .rd_addr(rd_addr),
      .rd_gnt(rd_gnt[g]), .rd_valid(rd_valid[g]), .rd_data(rd_data[g]),
      .ram_wen(ram_wen[g]), .ram_waddr(ram_waddr[g]), .ram_wdata(ram_wdata[g]),
      .ram_raddr(ram_raddr[g]), .ram_rdata(rdata)
    );

    // Read-first RAM: RD_LAT-1 output stages after the registered address.
    always @(posedge clk) begin
      if (ram_wen[g]) mem[ram_waddr[g]] <= ram_wdata[g];
      pipe[0] <= mem[ram_raddr[g]];
      pipe[1] <= pipe[0];
    end
    if (LAT[g] == 1) begin : g_l1
      assign rdata = mem[ram_raddr[g]];
    end else begin : g_ln
      assign rdata = pipe[LAT[g]-2];
    end
  end

  // Reference model state
  int            ptr_w [NI], ptr_r [NI], own_w [NI], own_r [NI];
  logic [DW-1:0] mmem [NI][256];
  bit            pend_v [NI];
  logic [AW-1:0] pend_a [NI];
  logic [DW-1:0] pend_d [NI];
  bit            e_wen [NI];
  logic [AW-1:0] e_waddr [NI], e_raddr [NI];
  logic [DW-1:0] e_wdata [NI], e_rdata [NI];
  bit            sv [NI][8];
  int            sk [NI][8];
  logic [DW-1:0] sd [NI][8];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic check(input string name, input int inst,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input int mode, input logic [N-1:0] req, input int ptr);
    int c;
    for (int i = 0; i < N; i++) begin
      c = (mode == 0) ? i : (ptr + i) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic arb(input int mode, input logic [N-1:0] req, input logic [N-1:0] lock,
                     inout int owner, inout int ptr, output int g);
    if (owner >= 0 && req[owner] && lock[owner]) g = owner;
    else begin
      g = pick(mode, req, ptr);
      if (g >= 0 && mode == 1) ptr = (g + 1) % N;
    end
    owner = g;
  endtask

  // One model step per cycle, run at the falling edge: compare, then advance.
  task automatic step();
    int wg, rg, slot, due;
    logic [N-1:0]  ev;
    logic [AW-1:0] a;
    logic [DW-1:0] rdv;
    slot = cyc % 8;
    for (int i = 0; i < NI; i++) begin
      wg = -1;
      rg = -1;
      if (!rst) begin
        ptr_w[i] = 0; ptr_r[i] = 0; own_w[i] = -1; own_r[i] = -1;
        pend_v[i] = 0; e_wen[i] = 0; e_waddr[i] = '0; e_wdata[i] = '0;
        e_raddr[i] = '0; e_rdata[i] = '0;
        for (int s = 0; s < 8; s++) sv[i][s] = 0;
      end else begin
        if (pend_v[i]) mmem[i][pend_a[i]] = pend_d[i];
        arb(MODE[i], wr_req, wr_lock, own_w[i], ptr_w[i], wg);
        arb(MODE[i], rd_req, rd_lock, own_r[i], ptr_r[i], rg);
      end
      ev = sv[i][slot] ? oh(sk[i][slot]) : '0;
      if (sv[i][slot]) e_rdata[i] = sd[i][slot];
      sv[i][slot] = 0;

      check("wr_gnt", i, wr_gnt[i], oh(wg));
      check("rd_gnt", i, rd_gnt[i], oh(rg));
      check("ram_wen", i, ram_wen[i], e_wen[i]);
      check("ram_waddr", i, ram_waddr[i], e_waddr[i]);
      check("ram_wdata", i, ram_wdata[i], e_wdata[i]);
      check("ram_raddr", i, ram_raddr[i], e_raddr[i]);
      check("rd_valid", i, rd_valid[i], ev);
      check("rd_data", i, rd_data[i], e_rdata[i]);

      if (rst) begin
        pend_v[i] = (wg >= 0);
        e_wen[i]  = (wg >= 0);
        if (wg >= 0) begin
          pend_a[i]  = wr_addr[wg*AW +: AW];
          pend_d[i]  = wr_data[wg*DW +: DW];
          e_waddr[i] = pend_a[i];
          e_wdata[i] = pend_d[i];
        end
        if (rg >= 0) begin
          a = rd_addr[rg*AW +: AW];
          e_raddr[i] = a;
          rdv = mmem[i][a];
`ifdef RAM_ARB_RAW_BYPASS_EN
          if (wg >= 0 && wr_addr[wg*AW +: AW] == a) rdv = wr_data[wg*DW +: DW];
`endif
          due = (cyc + LAT[i] + 1) % 8;
          sv[i][due] = 1;
          sk[i][due] = rg;
          sd[i][due] = rdv;
        end
      end
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    step();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[k*AW +: AW] = a;
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_r(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic idle();
    wr_req = '0; wr_lock = '0; rd_req = '0; rd_lock = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) begin sample(); nxt(); end
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] r_addr [3];
    logic [DW-1:0] r_data [3];
    int            r_cli  [3];
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 256; a++) mmem[i][a] = '0;
    idle();
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    #1 rst = 1'b0;

    // Reset with write requests pending: no grants until release.
    wr_req = 4'b1111;
    for (int k = 0; k < N; k++) set_w(k, 8'h44 + 8'(k), 96'h1234 + 96'(k));
    repeat (3) begin
      sample();
      for (int i = 0; i < NI; i++) check("lit_rst_wgnt", i, wr_gnt[i], 4'b0000);
      nxt();
    end
    rst = 1'b1;
    sample();
    check("lit_first_wgnt", 0, wr_gnt[0], 4'b0001);
    nxt();
    sample();
    check("lit_first_wen", 0, ram_wen[0], 1'b1);
    check("lit_first_waddr", 0, ram_waddr[0], 8'h44);
    check("lit_first_wdata", 0, ram_wdata[0], 96'h1234);
    nxt();

    // Round-robin rotation on the read port, and tag return two cycles later.
    do_reset();
    for (int k = 0; k < N; k++) set_r(k, 8'h30 + 8'(k));
    for (int c = 0; c < 10; c++) begin
      rd_req = (c < 8) ? 4'b1111 : 4'b0000;
      sample();
      if (c < 8) check("lit_rr_gnt", 1, rd_gnt[1], 4'b0001 << (c % 4));
      if (c >= 2) begin
        check("lit_rr_valid", 1, rd_valid[1], 4'b0001 << ((c - 2) % 4));
        check("lit_fp_valid", 0, rd_valid[0], 4'b0001);
      end
      nxt();
    end

    // Write lock by client 2 under round robin, then release goes to client 3.
    do_reset();
    wr_req = 4'b0010;
    sample(); nxt();
    wr_req = 4'b1111; wr_lock = 4'b0100;
    repeat (5) begin
      sample();
      check("lit_lock_gnt", 1, wr_gnt[1], 4'b0100);
      nxt();
    end
    wr_lock = 4'b0000;
    sample();
    check("lit_unlock_gnt", 1, wr_gnt[1], 4'b1000);
    nxt();
    // Lock overrides fixed priority as well.
    wr_req = 4'b1000; wr_lock = 4'b1000;
    sample(); nxt();
    wr_req = 4'b1111;
    sample();
    check("lit_fp_lock", 0, wr_gnt[0], 4'b1000);
    nxt();
    idle();

    // Same-address write and read in one cycle.
    wr_req = 4'b0001; set_w(0, 8'h10, 96'h3C);
    sample(); nxt();
    idle();
    sample(); nxt();
    wr_req = 4'b0001; set_w(0, 8'h10, 96'hA5);
    rd_req = 4'b0010; set_r(1, 8'h10);
    sample(); nxt();
    idle();
    sample(); nxt();
    sample();
    for (int i = 0; i < 2; i++) begin
      check("lit_raw_valid", i, rd_valid[i], 4'b0010);
      check("lit_raw_data", i, rd_data[i], RAW_EXP);
    end
    nxt();
    sample(); nxt();
    sample();
    check("lit_raw_valid", 2, rd_valid[2], 4'b0010);
    check("lit_raw_data", 2, rd_data[2], RAW_EXP);
    nxt();

    // Back-to-back reads with RD_LAT=3 by clients 0, 3, 1.
    r_cli  = '{0, 3, 1};
    r_addr = '{8'h20, 8'h23, 8'h21};
    r_data = '{96'h111, 96'h333, 96'h222};
    for (int j = 0; j < 3; j++) begin
      wr_req = 4'b0100; set_w(2, r_addr[j], r_data[j]);
      sample(); nxt();
    end
    idle();
    sample(); nxt();
    for (int c = 0; c < 7; c++) begin
      rd_req = '0;
      if (c < 3) begin
        rd_req = 4'b0001 << r_cli[c];
        set_r(r_cli[c], r_addr[c]);
      end
      sample();
      if (c >= 4) begin
        check("lit_l3_valid", 2, rd_valid[2], 4'b0001 << r_cli[c-4]);
        check("lit_l3_data", 2, rd_data[2], r_data[c-4]);
      end
      nxt();
    end

    // Reset one cycle after a read grant; the write in flight is dropped too.
    rd_req = 4'b0001; set_r(0, 8'h20);
    wr_req = 4'b0001; set_w(0, 8'h50, 96'h77);
    sample(); nxt();
    idle();
    rst = 1'b0;
    sample();
    for (int i = 0; i < NI; i++) check("lit_rst_wen", i, ram_wen[i], 1'b0);
    nxt();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      for (int i = 0; i < NI; i++) check("lit_rst_valid", i, rd_valid[i], 4'b0000);
      nxt();
    end
    rd_req = 4'b0001; set_r(0, 8'h50);
    sample(); nxt();
    idle();
    sample(); nxt();
    sample();
    check("lit_dropped_wr", 0, rd_data[0], 96'h0);
    nxt();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(199) != 0);
      wr_req  = 4'($urandom);
      rd_req  = 4'($urandom);
      wr_lock = 4'($urandom) & 4'($urandom);
      rd_lock = 4'($urandom) & 4'($urandom);
      for (int k = 0; k < N; k++) begin
        set_w(k, 8'($urandom_range(15)), {$urandom(), $urandom(), $urandom()});
        set_r(k, 8'($urandom_range(15)));
      end
      sample(); nxt();
    end
    rst = 1'b1;
    idle();
    repeat (6) begin sample(); nxt(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
